// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared ALU definitions used by the sequential divider:
//   - state_e        : divider FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width()    : width of the step counter for a given operand size
//   - DBZ_QUOT_FILL  : fill bit of the divide-by-zero quotient (all ones);
//                      the divide-by-zero remainder is the dividend itself
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter holds SIZE-1 down to 0, so $clog2(SIZE) bits suffice.
    // Clamp to one bit so SIZE=1 still yields a legal vector.
    function automatic int cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Divide-by-zero quotient is every bit set to this value.
    localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   r_i [SIZE-1:0] : partial remainder (low SIZE bits of R)
//   q_i [SIZE-1:0] : dividend/quotient shift register
//   d_i [SIZE-1:0] : divisor
//   r_o [SIZE-1:0] : next partial remainder
//   q_o [SIZE-1:0] : next shift register, new quotient bit shifted in at LSB
// The full restoring remainder is SIZE+1 bits, but because R < D holds after
// every step its top bit is always 0, so only the low SIZE bits are carried.
// -----------------------------------------------------------------------------
module div_step
    import seq_divider_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] r_i,
    input  logic [SIZE-1:0] q_i,
    input  logic [SIZE-1:0] d_i,
    output logic [SIZE-1:0] r_o,
    output logic [SIZE-1:0] q_o
);

    logic [SIZE:0] shifted;
    logic [SIZE:0] trial;
    logic          borrow;

    always_comb begin
        shifted = {r_i, q_i[SIZE-1]};
        trial   = shifted - {1'b0, d_i};
        borrow  = trial[SIZE];
        if (!borrow) begin
            r_o = trial[SIZE-1:0];
            q_o = (q_i << 1) | {{(SIZE-1){1'b0}}, 1'b1};
        end else begin
            // Restore: keep the shifted remainder, quotient bit is 0.
            r_o = shifted[SIZE-1:0];
            q_o = q_i << 1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request a divide; taken only while idle
//   dividend      : numerator, sampled on accept
//   divisor       : denominator, sampled on accept
//   busy          : high whenever not idle
//   done          : single-cycle pulse, results valid in that cycle
//   quotient      : registered quotient (all ones on divide by zero)
//   remainder     : registered remainder (dividend on divide by zero)
//   div_by_zero   : registered flag, set when the accepted divisor was 0
// Handshake: start is a request sampled only in IDLE; there is no ready
// output, busy low is the ready indication. Results and div_by_zero hold
// until the next accepted start produces new ones.
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = cnt_width(SIZE);

    state_e          state_q, state_d;
    logic [SIZE-1:0] r_q, r_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [SIZE-1:0] d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [SIZE-1:0] quotient_q, quotient_d;
    logic [SIZE-1:0] remainder_q, remainder_d;

    logic [SIZE-1:0] r_nxt;
    logic [SIZE-1:0] q_nxt;

    div_step #(.SIZE(SIZE)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_nxt),
        .q_o (q_nxt)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CW'(SIZE - 1);
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = {SIZE{DBZ_QUOT_FILL}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q - CW'(1);
                // Counter at 0 marks the final step; capture its result directly.
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = q_nxt;
                    remainder_d = r_nxt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule
